int_alu_shift_unit: RTL and testbench

Single-issue integer functional unit for the integer execution stage. It combines a RISC-V-style ALU and a barrel shifter behind one operation selector and registers the result. Result latency is one cycle. It feeds the integer register-write stage and the bypass network.

---
 rtl/int_alu_shift_unit_pkg.sv | 31 +++
 rtl/int_alu_shift_unit_if.sv | 30 +++
 rtl/int_shifter.sv | 63 ++++++
 rtl/int_alu_shift_unit.sv | 64 ++++++
 tb/tb_int_alu_shift_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_alu_shift_unit_pkg.sv
// rtl/int_alu_shift_unit_pkg.sv - shared types and widths for the integer ALU/shift unit
package int_alu_shift_unit_pkg;

    localparam int DATA_WIDTH            = 32;
    localparam int SHIFT_AMOUNT_BIT_SIZE = 5;

    // Codes 8-15 are reserved and produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_AND   = 4'd6,
        ALU_MOV_B = 4'd7
    } IntALU_Code;

    typedef enum logic {
        SOT_IMM_SHIFT = 1'b0,
        SOT_REG_SHIFT = 1'b1
    } ShiftOperandType;

    typedef enum logic [1:0] {
        ST_LSL = 2'd0,
        ST_LSR = 2'd1,
        ST_ASR = 2'd2,
        ST_ROR = 2'd3
    } ShiftType;

endpackage

// File: rtl/int_alu_shift_unit_if.sv
// rtl/int_alu_shift_unit_if.sv - issue/result bundle between execute stage and the ALU/shift unit
interface int_alu_shift_unit_if #(
    parameter int DATA_WIDTH            = int_alu_shift_unit_pkg::DATA_WIDTH,
    parameter int SHIFT_AMOUNT_BIT_SIZE = int_alu_shift_unit_pkg::SHIFT_AMOUNT_BIT_SIZE
);
    logic                             valid_in;
    logic                             op_type;
    logic [3:0]                       alu_code;
    logic [DATA_WIDTH-1:0]            op_a;
    logic [DATA_WIDTH-1:0]            op_b;
    logic                             shift_operand_type;
    logic [1:0]                       shift_type;
    logic [SHIFT_AMOUNT_BIT_SIZE-1:0] imm_shift;
    logic                             carry_in;
    logic                             valid_out;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             carry_out;

    modport master (
        output valid_in, op_type, alu_code, op_a, op_b, shift_operand_type,
               shift_type, imm_shift, carry_in,
        input  valid_out, data_out, carry_out
    );

    modport slave (
        input  valid_in, op_type, alu_code, op_a, op_b, shift_operand_type,
               shift_type, imm_shift, carry_in,
        output valid_out, data_out, carry_out
    );
endinterface

// File: rtl/int_shifter.sv
// rtl/int_shifter.sv - combinational barrel shifter with carry; rotate only when INT_ALU_ROR_EN is defined
module int_shifter
    import int_alu_shift_unit_pkg::ShiftType, int_alu_shift_unit_pkg::ST_LSL,
           int_alu_shift_unit_pkg::ST_LSR, int_alu_shift_unit_pkg::ST_ASR,
           int_alu_shift_unit_pkg::ST_ROR;
#(
    parameter int DATA_WIDTH            = int_alu_shift_unit_pkg::DATA_WIDTH,
    parameter int SHIFT_AMOUNT_BIT_SIZE = int_alu_shift_unit_pkg::SHIFT_AMOUNT_BIT_SIZE
) (
    input  logic [DATA_WIDTH-1:0]            shiftIn,
    input  logic [SHIFT_AMOUNT_BIT_SIZE-1:0] shiftAmount,
    input  ShiftType                         shiftType,
    input  logic                             carryIn,
    output logic [DATA_WIDTH-1:0]            shiftOut,
    output logic                             carryOut
);
    // One extra bit on each shifter catches the last bit shifted out as carry.
    logic [DATA_WIDTH:0] lslWide;
    logic [DATA_WIDTH:0] lsrWide;
    logic [DATA_WIDTH:0] asrWide;

    assign lslWide = {1'b0, shiftIn} << shiftAmount;
    assign lsrWide = {shiftIn, 1'b0} >> shiftAmount;
    assign asrWide = $signed({shiftIn, 1'b0}) >>> shiftAmount;

`ifdef INT_ALU_ROR_EN
    logic [DATA_WIDTH-1:0] rorData;
    assign rorData = (shiftIn >> shiftAmount) | (shiftIn << (DATA_WIDTH - int'(shiftAmount)));
`endif

    always_comb begin
        shiftOut = shiftIn;
        carryOut = carryIn;
        if (shiftAmount != '0) begin
            case (shiftType)
                ST_LSL: begin
                    shiftOut = lslWide[DATA_WIDTH-1:0];
                    carryOut = lslWide[DATA_WIDTH];
                end
                ST_ASR: begin
                    shiftOut = asrWide[DATA_WIDTH:1];
                    carryOut = asrWide[0];
                end
`ifdef INT_ALU_ROR_EN
                ST_ROR: begin
                    shiftOut = rorData;
                    carryOut = lsrWide[0];
                end
                ST_LSR: begin
`else
                ST_LSR, ST_ROR: begin
`endif
                    shiftOut = lsrWide[DATA_WIDTH:1];
                    carryOut = lsrWide[0];
                end
                default: begin
                    shiftOut = shiftIn;
                    carryOut = carryIn;
                end
            endcase
        end
    end
endmodule

// File: rtl/int_alu_shift_unit.sv
// rtl/int_alu_shift_unit.sv - registered integer ALU + shifter unit (rotate gated by INT_ALU_ROR_EN)
module int_alu_shift_unit #(
    parameter int DATA_WIDTH            = int_alu_shift_unit_pkg::DATA_WIDTH,
    parameter int SHIFT_AMOUNT_BIT_SIZE = int_alu_shift_unit_pkg::SHIFT_AMOUNT_BIT_SIZE
) (
    input logic                 clk,
    input logic                 rst,
    int_alu_shift_unit_if.slave bus
);
    import int_alu_shift_unit_pkg::*;

    logic [SHIFT_AMOUNT_BIT_SIZE-1:0] shiftAmount;
    logic [DATA_WIDTH-1:0]            shiftResult;
    logic                             shiftCarry;
    logic [DATA_WIDTH-1:0]            aluResult;
    logic [DATA_WIDTH-1:0]            resultNext;
    logic                             carryNext;

    assign shiftAmount = (ShiftOperandType'(bus.shift_operand_type) == SOT_REG_SHIFT)
                       ? bus.op_b[SHIFT_AMOUNT_BIT_SIZE-1:0] : bus.imm_shift;

    int_shifter #(
        .DATA_WIDTH            (DATA_WIDTH),
        .SHIFT_AMOUNT_BIT_SIZE (SHIFT_AMOUNT_BIT_SIZE)
    ) uShifter (
        .shiftIn     (bus.op_a),
        .shiftAmount (shiftAmount),
        .shiftType   (ShiftType'(bus.shift_type)),
        .carryIn     (bus.carry_in),
        .shiftOut    (shiftResult),
        .carryOut    (shiftCarry)
    );

    always_comb begin
        aluResult = '0;
        case (bus.alu_code)
            ALU_ADD:   aluResult = bus.op_a + bus.op_b;
            ALU_SUB:   aluResult = bus.op_a - bus.op_b;
            ALU_SLT:   aluResult = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU:  aluResult = {{(DATA_WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
            ALU_XOR:   aluResult = bus.op_a ^ bus.op_b;
            ALU_OR:    aluResult = bus.op_a | bus.op_b;
            ALU_AND:   aluResult = bus.op_a & bus.op_b;
            ALU_MOV_B: aluResult = bus.op_b;
            default:   aluResult = '0;
        endcase
    end

    // Carry is only meaningful for shifts; ALU ops always report zero.
    assign resultNext = bus.op_type ? shiftResult : aluResult;
    assign carryNext  = bus.op_type & shiftCarry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            bus.data_out  <= resultNext;
            bus.carry_out <= carryNext;
        end
    end
endmodule

// File: tb/tb_int_alu_shift_unit.sv
// tb/tb_int_alu_shift_unit.sv - scoreboard bench for int_alu_shift_unit (honours INT_ALU_ROR_EN)
module tb_int_alu_shift_unit;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        c;
    } exp_t;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;
    exp_t sbQueue[$];

    int_alu_shift_unit_if bus ();

    int_alu_shift_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model written bit-by-bit, independent of the RTL shifter structure.
    function automatic exp_t model(input logic v, input logic opType, input logic [3:0] code,
                                   input logic [31:0] a, input logic [31:0] b, input logic sot,
                                   input logic [1:0] st, input logic [4:0] imm, input logic cin);
        exp_t e;
        int n;
        logic [1:0] stEff;
        e.v = v;
        e.d = '0;
        e.c = 1'b0;
        if (!opType) begin
            case (code)
                4'd0: e.d = a + b;
                4'd1: e.d = a - b;
                4'd2: e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd3: e.d = (a < b) ? 32'd1 : 32'd0;
                4'd4: e.d = a ^ b;
                4'd5: e.d = a | b;
                4'd6: e.d = a & b;
                4'd7: e.d = b;
                default: e.d = '0;
            endcase
        end else begin
            n = sot ? int'(b[4:0]) : int'(imm);
            stEff = st;
`ifndef INT_ALU_ROR_EN
            if (st == 2'd3) stEff = 2'd1;
`endif
            if (n == 0) begin
                e.d = a;
                e.c = cin;
            end else begin
                for (int i = 0; i < 32; i++) begin
                    case (stEff)
                        2'd0:    e.d[i] = (i >= n) ? a[i-n] : 1'b0;
                        2'd1:    e.d[i] = (i + n < 32) ? a[i+n] : 1'b0;
                        2'd2:    e.d[i] = (i + n < 32) ? a[i+n] : a[31];
                        default: e.d[i] = a[(i+n)%32];
                    endcase
                end
                e.c = (stEff == 2'd0) ? a[32-n] : a[n-1];
            end
        end
        return e;
    endfunction

    task automatic issue(input logic v, input logic opType, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b, input logic sot,
                         input logic [1:0] st, input logic [4:0] imm, input logic cin,
                         input logic [31:0] expD, input logic expC);
        exp_t e;
        @(negedge clk);
        bus.valid_in           = v;
        bus.op_type            = opType;
        bus.alu_code           = code;
        bus.op_a               = a;
        bus.op_b               = b;
        bus.shift_operand_type = sot;
        bus.shift_type         = st;
        bus.imm_shift          = imm;
        bus.carry_in           = cin;
        e.v = v;
        e.d = expD;
        e.c = expC;
        sbQueue.push_back(e);
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            chk({tag, "_valid"}, {31'd0, bus.valid_out}, {31'd0, e.v});
            chk({tag, "_data"},  bus.data_out, e.d);
            chk({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, e.c});
        end
    endtask

    task automatic alu(input string tag, input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expD);
        issue(1'b1, 1'b0, code, a, b, 1'b0, 2'd0, 5'd0, 1'b1, expD, 1'b0);
        cycle(tag);
    endtask

    task automatic shiftImm(input string tag, input logic [1:0] st, input logic [31:0] a,
                            input logic [4:0] imm, input logic [31:0] expD, input logic expC);
        issue(1'b1, 1'b1, 4'd0, a, 32'h0, 1'b0, st, imm, 1'b0, expD, expC);
        cycle(tag);
    endtask

    initial begin
        exp_t r;
        logic rv, rop, rsot, rcin;
        logic [3:0] rcode;
        logic [31:0] ra, rb;
        logic [1:0] rst_t;
        logic [4:0] rimm;

        nCompared   = 0;
        nMismatched = 0;
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.op_type = 1'b0; bus.alu_code = 4'd0;
        bus.op_a = '0; bus.op_b = '0; bus.shift_operand_type = 1'b0;
        bus.shift_type = 2'd0; bus.imm_shift = '0; bus.carry_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("reset_data",  bus.data_out, 32'd0);
        chk("reset_carry", {31'd0, bus.carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("sub_neg",  4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("slt",      4'd2, 32'hFFFF_FFFF, 32'h1, 32'h1);
        alu("sltu",     4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("xor",      4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        alu("or",       4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        alu("and",      4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        alu("mov_b",    4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0FF0_0FF0);
        alu("rsvd9",    4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);

        shiftImm("lsl1", 2'd0, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1);
        shiftImm("lsr1", 2'd1, 32'h8000_0001, 5'd1, 32'h4000_0000, 1'b1);
        shiftImm("asr1", 2'd2, 32'h8000_0001, 5'd1, 32'hC000_0000, 1'b1);
`ifdef INT_ALU_ROR_EN
        shiftImm("ror1", 2'd3, 32'h8000_0001, 5'd1, 32'hC000_0000, 1'b1);
`else
        shiftImm("ror1", 2'd3, 32'h8000_0001, 5'd1, 32'h4000_0000, 1'b1);
`endif
        shiftImm("lsl31", 2'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1);

        issue(1'b1, 1'b1, 4'd0, 32'h0000_00F0, 32'h0000_0024, 1'b1, 2'd1, 5'd7, 1'b1, 32'h0000_000F, 1'b0);
        cycle("reg_lsr4");
        issue(1'b1, 1'b1, 4'd0, 32'h0000_00F0, 32'h0000_0020, 1'b1, 2'd1, 5'd7, 1'b1, 32'h0000_00F0, 1'b1);
        cycle("reg_n0");

        // Back-to-back: ADD, SHIFT, then an invalid op on consecutive cycles.
        issue(1'b1, 1'b0, 4'd0, 32'd3, 32'd4, 1'b0, 2'd0, 5'd0, 1'b0, 32'd7, 1'b0);
        cycle("b2b_add");
        issue(1'b1, 1'b1, 4'd0, 32'd1, 32'd0, 1'b0, 2'd0, 5'd4, 1'b0, 32'h10, 1'b0);
        cycle("b2b_shift");
        issue(1'b0, 1'b0, 4'd0, 32'd1, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 32'd2, 1'b0);
        cycle("b2b_idle");

        // Asynchronous reset while a valid op is in flight.
        issue(1'b1, 1'b0, 4'd0, 32'd10, 32'd20, 1'b0, 2'd0, 5'd0, 1'b0, 32'd30, 1'b0);
        cycle("pre_rst");
        issue(1'b1, 1'b0, 4'd0, 32'd11, 32'd22, 1'b0, 2'd0, 5'd0, 1'b0, 32'd33, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("async_rst_data",  bus.data_out, 32'd0);
        chk("async_rst_carry", {31'd0, bus.carry_out}, 32'd0);
        sbQueue.delete();
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_hold_data",  bus.data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        alu("post_rst", 4'd5, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);

        for (int k = 0; k < 40; k++) begin
            rv    = ($urandom_range(0, 3) != 0);
            rop   = $urandom_range(0, 1);
            rcode = $urandom_range(0, 15);
            ra    = $urandom;
            rb    = $urandom;
            rsot  = $urandom_range(0, 1);
            rst_t = $urandom_range(0, 3);
            rimm  = (k % 5 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rcin  = $urandom_range(0, 1);
            r = model(rv, rop, rcode, ra, rb, rsot, rst_t, rimm, rcin);
            issue(rv, rop, rcode, ra, rb, rsot, rst_t, rimm, rcin, r.d, r.c);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
